// File: rtl/multicycle_alu.sv
// Registered WIDTH-bit ALU with narrow (WIDTH/2) mode and a {Z,C,N,O} flag register.
// MUL (shift-add) and DIVU (restoring) run one bit per cycle under a small FSM.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic             Narrow,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WF,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       FlagsOut,
  output logic [1:0]       DbgState
);
  // Handshake: a request is taken at any rising edge with Start=1 and Busy=0; Op, Narrow,
  // A, B and WF are captured there. Done pulses for exactly one cycle when Result,
  // ResultHi and FlagsOut are updated; a new request may be taken on that same edge.
  localparam int NW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} stateE;
  stateE state, stateNext;

  logic               accept, nR, wfR, lastIter;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   lowMask, aE, bE, addB, raw, rawM, topBit;
  logic [WIDTH:0]     sum;
  logic               addCin, addCout, addOvf, cOut, oOut;
  logic [2*WIDTH-1:0] acc, mcand, accNext;
  logic [WIDTH-1:0]   mplier, rem, quo, divisor, remNext, quoNext, quoM;
  logic [WIDTH:0]     remShift;
  logic               remGe;

  function automatic logic msbOf(input logic [WIDTH-1:0] v, input logic nar);
    return nar ? v[NW-1] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] fitResult(input logic [WIDTH-1:0] v, input logic nar);
    return nar ? {{NW{v[NW-1]}}, v[NW-1:0]} : v;
  endfunction

  assign lowMask = Narrow ? {{NW{1'b0}}, {NW{1'b1}}} : '1;
  assign topBit  = Narrow ? {{NW{1'b0}}, 1'b1, {(NW-1){1'b0}}} : {1'b1, {(WIDTH-1){1'b0}}};
  assign aE      = A & lowMask;
  assign bE      = B & lowMask;
  assign accept  = Start && !Busy;
  assign lastIter = (cnt == (nR ? CW'(NW - 1) : CW'(WIDTH - 1)));

  // Single-cycle datapath; subtraction is A + ~B + 1 so C means "no borrow".
  always_comb begin
    addB    = (Op == 4'b0110) ? (~B & lowMask) : bE;
    addCin  = (Op == 4'b0110) ? 1'b1 : ((Op == 4'b0101) ? FlagsOut[2] : 1'b0);
    sum     = {1'b0, aE} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};
    addCout = Narrow ? sum[NW] : sum[WIDTH];
    addOvf  = (msbOf(aE, Narrow) == msbOf(addB, Narrow)) &&
              (msbOf(sum[WIDTH-1:0], Narrow) != msbOf(aE, Narrow));
    raw  = '0;
    cOut = FlagsOut[2];
    oOut = FlagsOut[0];
    unique case (Op)
      4'b0000: raw = aE;
      4'b0001: raw = bE;
      4'b0010: raw = ~aE;
      4'b0011: raw = ~bE;
      4'b0100, 4'b0101, 4'b0110: begin
        raw  = sum[WIDTH-1:0];
        cOut = addCout;
        oOut = addOvf;
      end
      4'b0111: raw = aE & bE;
      4'b1000: raw = aE | bE;
      4'b1001: raw = aE ^ bE;
      4'b1010: raw = ~(aE & bE);
      4'b1011: begin raw = aE << 1; cOut = msbOf(aE, Narrow); end
      4'b1100: begin raw = aE >> 1; cOut = aE[0]; end
      4'b1101: begin raw = (aE >> 1) | (msbOf(aE, Narrow) ? topBit : '0); cOut = aE[0]; end
      default: raw = '0;
    endcase
    rawM = raw & lowMask;
  end

  // One iteration of shift-add multiply and restoring divide.
  always_comb begin
    accNext  = acc + (mplier[0] ? mcand : '0);
    remShift = {rem, quo[WIDTH-1]};
    remGe    = (remShift >= {1'b0, divisor});
    remNext  = remGe ? WIDTH'(remShift - {1'b0, divisor}) : remShift[WIDTH-1:0];
    quoNext  = {quo[WIDTH-2:0], remGe};
    quoM     = nR ? {{NW{1'b0}}, quoNext[NW-1:0]} : quoNext;
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (accept && Op == 4'b1110)            stateNext = MUL;
            else if (accept && Op == 4'b1111 && bE != '0) stateNext = DIV;
      MUL, DIV: if (lastIter) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    Busy     = (state != IDLE);
    DbgState = state;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Done <= 1'b0; Result <= '0; ResultHi <= '0; FlagsOut <= '0;
      nR <= 1'b0; wfR <= 1'b0; cnt <= '0;
      acc <= '0; mcand <= '0; mplier <= '0;
      rem <= '0; quo <= '0; divisor <= '0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        nR  <= Narrow;
        wfR <= WF;
        cnt <= '0;
        if (Op == 4'b1110) begin
          acc <= '0; mcand <= {{WIDTH{1'b0}}, aE}; mplier <= bE;
        end else if (Op == 4'b1111 && bE != '0) begin
          rem <= '0; divisor <= bE;
          quo <= Narrow ? (aE << NW) : aE;
        end else if (Op == 4'b1111) begin
          Result   <= '1;
          ResultHi <= aE;
          Done     <= 1'b1;
          if (WF) FlagsOut <= {1'b0, FlagsOut[2], 1'b1, 1'b1};
        end else begin
          Result   <= fitResult(rawM, Narrow);
          ResultHi <= '0;
          Done     <= 1'b1;
          if (WF) FlagsOut <= {(rawM == '0), cOut, msbOf(rawM, Narrow), oOut};
        end
      end else if (state == MUL) begin
        acc    <= accNext;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (lastIter) begin
          Done     <= 1'b1;
          Result   <= accNext[WIDTH-1:0];
          ResultHi <= nR ? '0 : accNext[2*WIDTH-1:WIDTH];
          if (wfR) begin
            if (nR) FlagsOut <= {(accNext[NW-1:0] == '0), (accNext[WIDTH-1:NW] != '0),
                                 accNext[NW-1], FlagsOut[0]};
            else    FlagsOut <= {(accNext[WIDTH-1:0] == '0), (accNext[2*WIDTH-1:WIDTH] != '0),
                                 accNext[WIDTH-1], FlagsOut[0]};
          end
        end
      end else if (state == DIV) begin
        rem <= remNext;
        quo <= quoNext;
        cnt <= cnt + 1'b1;
        if (lastIter) begin
          Done     <= 1'b1;
          Result   <= fitResult(quoM, nR);
          ResultHi <= remNext;
          if (wfR) FlagsOut <= {(quoM == '0), FlagsOut[2], msbOf(quoM, nR), 1'b0};
        end
      end
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: a driver issues ops and queues expected results,
// and a monitor compares them whenever Done pulses.
module tb_multicycle_alu;
  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset, Start, Narrow, WF;
  logic [3:0]   Op;
  logic [W-1:0] A, B;
  logic         Busy, Done;
  logic [W-1:0] Result, ResultHi;
  logic [3:0]   FlagsOut;
  logic [1:0]   DbgState;

  int total = 0;
  int bad   = 0;
  logic [2*W+3:0] expQ[$];

  multicycle_alu #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .Narrow(Narrow),
    .A(A), .B(B), .WF(WF), .Busy(Busy), .Done(Done), .Result(Result),
    .ResultHi(ResultHi), .FlagsOut(FlagsOut), .DbgState(DbgState)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest queued expectation.
  always @(negedge Clock) begin : monitor
    logic [2*W+3:0] e;
    if (Done === 1'b1) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got Done=1 expected no pending op");
      end else begin
        e = expQ.pop_front();
        check("result",   32'(Result),   32'(e[2*W+3:W+4]));
        check("resultHi", 32'(ResultHi), 32'(e[W+3:4]));
        check("flags",    32'(FlagsOut), 32'(e[3:0]));
      end
    end
  end

  task automatic runOp(input string name, input logic [3:0] op, input logic nar,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic wf,
                       input logic [W-1:0] eRes, input logic [W-1:0] eHi,
                       input logic [3:0] eFl, input int eBusy, input int poke);
    int busyCnt;
    bit seen;
    @(negedge Clock);
    Start = 1'b1; Op = op; Narrow = nar; A = a; B = b; WF = wf;
    expQ.push_back({eRes, eHi, eFl});
    @(negedge Clock);
    Start = 1'b0;
    A = W'($urandom_range(0, 65535));
    B = W'($urandom_range(0, 65535));
    busyCnt = 0;
    seen = 0;
    for (int waitCnt = 0; waitCnt < 40 && !seen; waitCnt++) begin
      if (Done === 1'b1) seen = 1;
      else begin
        if (Busy === 1'b1) busyCnt++;
        Start = (waitCnt == poke);
        @(negedge Clock);
      end
    end
    Start = 1'b0;
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_busy_cycles"}, 32'(busyCnt), 32'(eBusy));
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = '0; Narrow = 1'b0; A = '0; B = '0; WF = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_result",   32'(Result),   32'd0);
    check("rst_resultHi", 32'(ResultHi), 32'd0);
    check("rst_flags",    32'(FlagsOut), 32'd0);
    check("rst_busy",     32'(Busy),     32'd0);
    check("rst_done",     32'(Done),     32'd0);
    check("rst_state",    32'(DbgState), 32'd0);
    Reset = 1'b0;

    //    name        op       nar   A        B        wf    Result   ResultHi flags    busy poke
    runOp("add",      4'b0100, 1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5555, 16'h0000, 4'b0000, 0,  -1);
    runOp("nsub1",    4'b0110, 1'b1, 16'h00BD, 16'h0035, 1'b1, 16'hFF88, 16'h0000, 4'b0110, 0,  -1);
    runOp("nsub2",    4'b0110, 1'b1, 16'h00FD, 16'h007F, 1'b1, 16'h007E, 16'h0000, 4'b0101, 0,  -1);
    runOp("sub",      4'b0110, 1'b0, 16'h4E20, 16'h9E58, 1'b1, 16'hAFC8, 16'h0000, 4'b0011, 0,  -1);
    runOp("sub_nowf", 4'b0110, 1'b0, 16'h4E20, 16'h9E58, 1'b0, 16'hAFC8, 16'h0000, 4'b0011, 0,  -1);
    runOp("mul",      4'b1110, 1'b0, 16'h1234, 16'h0100, 1'b1, 16'h3400, 16'h0012, 4'b0101, 16, 3);
    runOp("divu",     4'b1111, 1'b0, 16'h0064, 16'h0007, 1'b1, 16'h000E, 16'h0002, 4'b0100, 16, -1);
    runOp("div0",     4'b1111, 1'b0, 16'h0064, 16'h0000, 1'b1, 16'hFFFF, 16'h0064, 4'b0111, 0,  -1);

    // Abort a MUL with reset in its fifth busy cycle; it must leave no trace.
    @(negedge Clock);
    Start = 1'b1; Op = 4'b1110; Narrow = 1'b0; A = 16'h1234; B = 16'h0100; WF = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_busy",     32'(Busy),     32'd0);
    check("abort_done",     32'(Done),     32'd0);
    check("abort_result",   32'(Result),   32'd0);
    check("abort_resultHi", 32'(ResultHi), 32'd0);
    check("abort_flags",    32'(FlagsOut), 32'd0);
    Reset = 1'b0;
    repeat (20) @(negedge Clock);

    runOp("nlsl",     4'b1011, 1'b1, 16'h00A5, 16'h0000, 1'b1, 16'h004A, 16'h0000, 4'b0100, 0,  -1);
    runOp("adc",      4'b0101, 1'b0, 16'h0001, 16'h0002, 1'b1, 16'h0004, 16'h0000, 4'b0000, 0,  -1);
    runOp("and",      4'b0111, 1'b0, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 16'h0000, 4'b0010, 0,  -1);
    runOp("xor",      4'b1001, 1'b0, 16'hF0F0, 16'hF0F0, 1'b1, 16'h0000, 16'h0000, 4'b1000, 0,  -1);
    runOp("lsr",      4'b1100, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0000, 4'b1100, 0,  -1);
    runOp("asr",      4'b1101, 1'b0, 16'h8002, 16'h0000, 1'b1, 16'hC001, 16'h0000, 4'b0010, 0,  -1);
    runOp("nnot",     4'b0010, 1'b1, 16'h000F, 16'h0000, 1'b1, 16'hFFF0, 16'h0000, 4'b0010, 0,  -1);
    runOp("nmul",     4'b1110, 1'b1, 16'h00FF, 16'h00FF, 1'b1, 16'hFE01, 16'h0000, 4'b0100, 8,  -1);
    runOp("ndiv",     4'b1111, 1'b1, 16'h00FF, 16'h0010, 1'b1, 16'h000F, 16'h000F, 4'b0100, 8,  -1);
    runOp("nor",      4'b1000, 1'b1, 16'h0080, 16'h0001, 1'b1, 16'hFF81, 16'h0000, 4'b0110, 0,  -1);
    runOp("movb",     4'b0001, 1'b0, 16'h1111, 16'h0000, 1'b1, 16'h0000, 16'h0000, 4'b1100, 0,  -1);

    repeat (3) @(negedge Clock);
    check("queue_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
